// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter
// Two-requester round-robin arbiter driving the select line of a 2:1 mux.
// One source is granted at a time. While the other source is waiting, a
// grant lasts at most BURST_MAX cycles. The select line only moves when the
// grant passes to the other source, so the mux output never glitches.
// Every output comes straight from a flop.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - synchronous active-low reset
//   req_a      - request from source A (mux in_A)
//   req_b      - request from source B (mux in_B)
//   selector   - mux select, 0 = in_A, 1 = in_B; holds its value while idle
//   gnt_a      - grant to A
//   gnt_b      - grant to B
//   busy       - gnt_a | gnt_b
//   burst_cnt  - cycles the current grant has been held (1-based), 0 when idle
//   state_dbg  - current FSM state (0 IDLE, 1 GNT_A, 2 GNT_B), for checkers
//
// Handshake: req_x is a level request that the requester holds for as long as
// it wants the mux. gnt_x rises one edge after req_x is sampled high, once
// the arbiter chooses x. The requester owns the mux on every cycle that gnt_x
// is high. Dropping req_x releases the mux on the next edge. A grant can also
// be withdrawn while req_x is still high when the burst limit forces a switch.
module mux_sel_arbiter #(
  parameter int unsigned BURST_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_a,
  input  logic       req_b,
  output logic       selector,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       busy,
  output logic [7:0] burst_cnt,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  localparam logic [7:0] BMAX = 8'(BURST_MAX);

  state_t     state;
  state_t     state_nxt;
  logic       last;       // 0 = A granted most recently, 1 = B
  logic       last_nxt;
  logic       sel_nxt;
  logic [7:0] cnt_nxt;

  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    sel_nxt   = selector;
    cnt_nxt   = burst_cnt;

    case (state)
      IDLE: begin
        // On a tie, the source that was not granted most recently wins.
        if (req_a && req_b)  state_nxt = last ? GNT_A : GNT_B;
        else if (req_a)      state_nxt = GNT_A;
        else if (req_b)      state_nxt = GNT_B;
      end
      GNT_A: begin
        if (!req_a)                          state_nxt = req_b ? GNT_B : IDLE;
        else if (req_b && burst_cnt == BMAX) state_nxt = GNT_B;
      end
      GNT_B: begin
        if (!req_b)                          state_nxt = req_a ? GNT_A : IDLE;
        else if (req_a && burst_cnt == BMAX) state_nxt = GNT_A;
      end
      default: state_nxt = IDLE;
    endcase

    // The counter, select line and last-owner bit depend only on whether the
    // grant is dropped, kept, or newly given to a source.
    if (state_nxt == IDLE) begin
      cnt_nxt = 8'd0;
    end else if (state_nxt == state) begin
      // When saturated, the owner keeps the grant until the other side asks.
      cnt_nxt = (burst_cnt == BMAX) ? burst_cnt : burst_cnt + 8'd1;
    end else begin
      cnt_nxt  = 8'd1;
      last_nxt = (state_nxt == GNT_B);
      sel_nxt  = (state_nxt == GNT_B);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= 1'b1;   // B counts as last, so A wins the first tie
      selector  <= 1'b0;
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b0;
      busy      <= 1'b0;
      burst_cnt <= 8'd0;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      selector  <= sel_nxt;
      gnt_a     <= (state_nxt == GNT_A);
      gnt_b     <= (state_nxt == GNT_B);
      busy      <= (state_nxt != IDLE);
      burst_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Testbench for mux_sel_arbiter. Two instances share the same inputs:
// dut4 has BURST_MAX=4 and dut1 has BURST_MAX=1. A behavioural model tracks
// the owner, the hold count and the last owner of each instance.
module tb_mux_sel_arbiter;

  logic clk;
  logic rst_n;
  logic req_a;
  logic req_b;

  logic       selector4, gnt_a4, gnt_b4, busy4;
  logic [7:0] burst_cnt4;
  logic [1:0] state_dbg4;
  logic       selector1, gnt_a1, gnt_b1, busy1;
  logic [7:0] burst_cnt1;
  logic [1:0] state_dbg1;

  int n_cmp = 0;
  int n_fail = 0;

  // Model state, index 0 = dut4, index 1 = dut1.
  // owner: 0 none, 1 A, 2 B. last: 1 A, 2 B.
  int  m_owner [2];
  int  m_cnt   [2];
  int  m_last  [2];
  bit  m_sel   [2];
  int  bmax    [2] = '{4, 1};

  mux_sel_arbiter #(.BURST_MAX(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
    .selector(selector4), .gnt_a(gnt_a4), .gnt_b(gnt_b4), .busy(busy4),
    .burst_cnt(burst_cnt4), .state_dbg(state_dbg4)
  );

  mux_sel_arbiter #(.BURST_MAX(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
    .selector(selector1), .gnt_a(gnt_a1), .gnt_b(gnt_b1), .busy(busy1),
    .burst_cnt(burst_cnt1), .state_dbg(state_dbg1)
  );

  // Packed view of all outputs: {selector, gnt_a, gnt_b, busy, burst_cnt}.
  logic [11:0] got4, got1;
  assign got4 = {selector4, gnt_a4, gnt_b4, busy4, burst_cnt4};
  assign got1 = {selector1, gnt_a1, gnt_b1, busy1, burst_cnt1};

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  task automatic model_step(input int k, input bit ra, input bit rb, input bit rn);
    int nxt;
    bit rx, ry;
    int other;
    if (!rn) begin
      m_owner[k] = 0; m_cnt[k] = 0; m_last[k] = 2; m_sel[k] = 1'b0;
      return;
    end
    if (m_owner[k] == 0) begin
      if (ra && rb)  nxt = (m_last[k] == 1) ? 2 : 1;
      else if (ra)   nxt = 1;
      else if (rb)   nxt = 2;
      else           nxt = 0;
    end else begin
      other = 3 - m_owner[k];
      rx = (m_owner[k] == 1) ? ra : rb;
      ry = (m_owner[k] == 1) ? rb : ra;
      if (!rx)                          nxt = ry ? other : 0;
      else if (ry && m_cnt[k] == bmax[k]) nxt = other;
      else                              nxt = m_owner[k];
    end
    if (nxt == 0) begin
      m_cnt[k] = 0;
    end else if (nxt == m_owner[k]) begin
      m_cnt[k] = (m_cnt[k] + 1 > bmax[k]) ? bmax[k] : m_cnt[k] + 1;
    end else begin
      m_cnt[k]  = 1;
      m_last[k] = nxt;
      m_sel[k]  = (nxt == 2);
    end
    m_owner[k] = nxt;
  endtask

  function automatic logic [11:0] exp_vec(input int k);
    return {m_sel[k], m_owner[k] == 1, m_owner[k] == 2, m_owner[k] != 0, 8'(m_cnt[k])};
  endfunction

  // ---------------- driver tasks ----------------
  // Advance one edge, update the model with the sampled inputs, then settle
  // 1 time unit past the edge so outputs can be sampled.
  task automatic step();
    @(posedge clk);
    model_step(0, req_a, req_b, rst_n);
    model_step(1, req_a, req_b, rst_n);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; req_a = 1'b1; req_b = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (got4 !== 12'h000) begin
        n_fail++;
        $display("FAIL reset_outs4 cyc=%0d got=%h exp=000", i, got4);
      end
      n_cmp++;
      if (got1 !== 12'h000) begin
        n_fail++;
        $display("FAIL reset_outs1 cyc=%0d got=%h exp=000", i, got1);
      end
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (got4 !== {1'b0, 1'b1, 1'b0, 1'b1, 8'd1}) begin
      n_fail++;
      $display("FAIL reset_first_grant got=%h exp=%h", got4, {1'b0, 1'b1, 1'b0, 1'b1, 8'd1});
    end
  endtask

  task automatic test_single_b();
    do_reset();
    req_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (got4 !== {1'b1, 1'b0, 1'b1, 1'b1, 8'(i + 1)}) begin
        n_fail++;
        $display("FAIL single_b cyc=%0d got=%h exp=%h", i, got4, {1'b1, 1'b0, 1'b1, 1'b1, 8'(i + 1)});
      end
    end
    req_b = 1'b0;
    step();
    n_cmp++;
    if (got4 !== {1'b1, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL single_b_idle got=%h exp=%h", got4, {1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
    end
  endtask

  task automatic test_contention();
    bit exp_a;
    do_reset();
    req_a = 1'b1; req_b = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      exp_a = ((i / 4) % 2 == 0);
      n_cmp++;
      if (got4 !== {~exp_a, exp_a, ~exp_a, 1'b1, 8'(i % 4 + 1)}) begin
        n_fail++;
        $display("FAIL contention cyc=%0d got=%h exp=%h", i, got4,
                 {~exp_a, exp_a, ~exp_a, 1'b1, 8'(i % 4 + 1)});
      end
    end
  endtask

  task automatic test_saturate();
    int exp_cnt;
    do_reset();
    req_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      exp_cnt = (i + 1 > 4) ? 4 : i + 1;
      n_cmp++;
      if (got4 !== {1'b0, 1'b1, 1'b0, 1'b1, 8'(exp_cnt)}) begin
        n_fail++;
        $display("FAIL saturate cyc=%0d got=%h exp=%h", i, got4, {1'b0, 1'b1, 1'b0, 1'b1, 8'(exp_cnt)});
      end
    end
    req_b = 1'b1;
    step();
    n_cmp++;
    if (got4 !== {1'b1, 1'b0, 1'b1, 1'b1, 8'd1}) begin
      n_fail++;
      $display("FAIL saturate_switch got=%h exp=%h", got4, {1'b1, 1'b0, 1'b1, 1'b1, 8'd1});
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req_b = 1'b1;
    step();
    step();
    n_cmp++;
    if (got4 !== {1'b1, 1'b0, 1'b1, 1'b1, 8'd2}) begin
      n_fail++;
      $display("FAIL mid_reset_setup got=%h exp=%h", got4, {1'b1, 1'b0, 1'b1, 1'b1, 8'd2});
    end
    req_a = 1'b1;
    rst_n = 1'b0;
    step();
    n_cmp++;
    if (got4 !== 12'h000) begin
      n_fail++;
      $display("FAIL mid_reset_drop got=%h exp=000", got4);
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (got4 !== {1'b0, 1'b1, 1'b0, 1'b1, 8'd1}) begin
      n_fail++;
      $display("FAIL mid_reset_regrant got=%h exp=%h", got4, {1'b0, 1'b1, 1'b0, 1'b1, 8'd1});
    end
  endtask

  task automatic test_burst1();
    bit exp_a;
    do_reset();
    req_a = 1'b1; req_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      exp_a = (i % 2 == 0);
      n_cmp++;
      if (got1 !== {~exp_a, exp_a, ~exp_a, 1'b1, 8'd1}) begin
        n_fail++;
        $display("FAIL burst1 cyc=%0d got=%h exp=%h", i, got1, {~exp_a, exp_a, ~exp_a, 1'b1, 8'd1});
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      req_a = ($urandom_range(0, 3) != 0);
      req_b = ($urandom_range(0, 2) != 0);
      step();
      n_cmp++;
      if (got4 !== exp_vec(0)) begin
        n_fail++;
        $display("FAIL random4 cyc=%0d got=%h exp=%h", i, got4, exp_vec(0));
      end
      n_cmp++;
      if (got1 !== exp_vec(1)) begin
        n_fail++;
        $display("FAIL random1 cyc=%0d got=%h exp=%h", i, got1, exp_vec(1));
      end
      n_cmp++;
      if ((gnt_a4 && gnt_b4) || (gnt_a1 && gnt_b1)) begin
        n_fail++;
        $display("FAIL grant_exclusive cyc=%0d got4=%b%b got1=%b%b exp=not both",
                 i, gnt_a4, gnt_b4, gnt_a1, gnt_b1);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = 0; m_cnt[k] = 0; m_last[k] = 2; m_sel[k] = 1'b0;
    end
    #2;
    test_reset();
    test_single_b();
    test_contention();
    test_saturate();
    test_reset_mid_grant();
    test_burst1();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
